// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and constants for the fetch sequencer.
//   fetch_state_e : sequencer state encoding
//   PC_INC        : sequential fetch stride in bytes
//   REG_W         : register specifier width
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT      = 2'd0,
    ST_RUN       = 2'd1,
    ST_LU_STALL  = 2'd2,
    ST_IMEM_WAIT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_INC = 32'd4;
  localparam int          REG_W  = 5;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use hazard compare.
// Ports:
//   ex_mem_read_i : instruction in EX is a load
//   ex_rt_i       : destination register of that load
//   id_rs_i       : Rs of the instruction in ID
//   id_rt_i       : Rt of the instruction in ID
//   id_uses_rt_i  : instruction in ID reads Rt as a source
//   lu_o          : load-use hazard present
module hazard_detect
  import fetch_ctrl_pkg::*;
(
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  output logic             lu_o
);

  // $0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lu_o = ex_mem_read_i && (ex_rt_i != '0) &&
                ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: next-PC sequencer and hazard controller beside the IF PC register.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   PC                  : current PC register value
//   IMem_Ready          : instruction memory delivers a word this cycle
//   IF_ID_Rs/Rt/UsesRt  : source operands of the instruction in ID
//   ID_EX_MemRead/Rt    : load in EX and its destination
//   Branch_Taken/Target : taken branch resolved in ID
//   Jump/Jump_Target    : jump in ID
//   Next_Instruction    : value the PC register loads at the next edge
//   PCWrite, IF_ID_Write, IF_Flush, ID_EX_Bubble : pipeline control (combinational)
//   Stall_Cnt, Flush_Cnt: saturating event counters
//
// state        | meaning
// ST_BOOT      | load RESET_PC, flush IF/ID
// ST_RUN       | normal fetch, hazard detection active
// ST_LU_STALL  | one cycle after a load-use stall, hazard detection masked
// ST_IMEM_WAIT | instruction memory stalled, redirect held in pending register
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PC,
  input  logic             IMem_Ready,
  input  logic [REG_W-1:0] IF_ID_Rs,
  input  logic [REG_W-1:0] IF_ID_Rt,
  input  logic             IF_ID_UsesRt,
  input  logic             ID_EX_MemRead,
  input  logic [REG_W-1:0] ID_EX_Rt,
  input  logic             Branch_Taken,
  input  logic [31:0]      Branch_Target,
  input  logic             Jump,
  input  logic [31:0]      Jump_Target,
  output logic [31:0]      Next_Instruction,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_Flush,
  output logic             ID_EX_Bubble,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt
);

  fetch_state_e     state_q, state_d;
  logic             pend_valid_q, pend_valid_d;
  logic [31:0]      pend_target_q, pend_target_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic        lu;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_seq;
  logic        stall_inc;
  logic        flush_inc;

  hazard_detect u_hazard_detect (
    .ex_mem_read_i (ID_EX_MemRead),
    .ex_rt_i       (ID_EX_Rt),
    .id_rs_i       (IF_ID_Rs),
    .id_rt_i       (IF_ID_Rt),
    .id_uses_rt_i  (IF_ID_UsesRt),
    .lu_o          (lu)
  );

  // Jump outranks a simultaneous taken branch.
  assign redirect        = Jump | Branch_Taken;
  assign redirect_target = Jump ? Jump_Target : Branch_Target;
  assign pc_seq          = PC + PC_INC;

  always_comb begin
    Next_Instruction = PC;
    PCWrite          = 1'b0;
    IF_ID_Write      = 1'b1;
    IF_Flush         = 1'b0;
    ID_EX_Bubble     = 1'b0;
    state_d          = state_q;
    pend_valid_d     = pend_valid_q;
    pend_target_d    = pend_target_q;
    stall_inc        = 1'b0;
    flush_inc        = 1'b0;

    if (rst) begin
      Next_Instruction = RESET_PC;
      PCWrite          = 1'b1;
      IF_Flush         = 1'b1;
    end else begin
      case (state_q)
        ST_BOOT: begin
          Next_Instruction = RESET_PC;
          PCWrite          = 1'b1;
          IF_Flush         = 1'b1;
          state_d          = ST_RUN;
        end

        ST_RUN, ST_LU_STALL: begin
          state_d = ST_RUN;
          // Redirects are ignored during the stall; the branch re-resolves next cycle.
          if ((state_q == ST_RUN) && lu) begin
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            stall_inc    = 1'b1;
            state_d      = ST_LU_STALL;
          end else if (redirect) begin
            Next_Instruction = redirect_target;
            IF_Flush         = 1'b1;
            flush_inc        = 1'b1;
            if (IMem_Ready) begin
              PCWrite = 1'b1;
            end else begin
              pend_valid_d  = 1'b1;
              pend_target_d = redirect_target;
              state_d       = ST_IMEM_WAIT;
            end
          end else if (!IMem_Ready) begin
            IF_Flush = 1'b1;
            state_d  = ST_IMEM_WAIT;
          end else begin
            Next_Instruction = pc_seq;
            PCWrite          = 1'b1;
          end
        end

        ST_IMEM_WAIT: begin
          IF_Flush = 1'b1;
          if (redirect) begin
            pend_valid_d  = 1'b1;
            pend_target_d = redirect_target;
            flush_inc     = 1'b1;
          end
          if (IMem_Ready) begin
            // A redirect arriving on the ready cycle is the newest and wins.
            if (redirect) begin
              Next_Instruction = redirect_target;
            end else if (pend_valid_q) begin
              Next_Instruction = pend_target_q;
            end else begin
              Next_Instruction = pc_seq;
            end
            IF_Flush     = redirect | pend_valid_q;
            PCWrite      = 1'b1;
            pend_valid_d = 1'b0;
            state_d      = ST_RUN;
          end
        end

        default: state_d = ST_BOOT;
      endcase
    end

    stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign Stall_Cnt = stall_cnt_q;
  assign Flush_Cnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl. Narrow counters make saturation reachable.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic        IMem_Ready;
  logic [4:0]  IF_ID_Rs, IF_ID_Rt, ID_EX_Rt;
  logic        IF_ID_UsesRt, ID_EX_MemRead;
  logic        Branch_Taken, Jump;
  logic [31:0] Branch_Target, Jump_Target;
  logic [31:0] Next_Instruction;
  logic        PCWrite, IF_ID_Write, IF_Flush, ID_EX_Bubble;
  logic [3:0]  Stall_Cnt, Flush_Cnt;

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .PC               (PC),
    .IMem_Ready       (IMem_Ready),
    .IF_ID_Rs         (IF_ID_Rs),
    .IF_ID_Rt         (IF_ID_Rt),
    .IF_ID_UsesRt     (IF_ID_UsesRt),
    .ID_EX_MemRead    (ID_EX_MemRead),
    .ID_EX_Rt         (ID_EX_Rt),
    .Branch_Taken     (Branch_Taken),
    .Branch_Target    (Branch_Target),
    .Jump             (Jump),
    .Jump_Target      (Jump_Target),
    .Next_Instruction (Next_Instruction),
    .PCWrite          (PCWrite),
    .IF_ID_Write      (IF_ID_Write),
    .IF_Flush         (IF_Flush),
    .ID_EX_Bubble     (ID_EX_Bubble),
    .Stall_Cnt        (Stall_Cnt),
    .Flush_Cnt        (Flush_Cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] ni;
    logic        pcw, ifw, fl, bub;
    logic [3:0]  sc, fc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] sc = 4'd0;
  logic [3:0] fc = 4'd0;

  function automatic logic [3:0] sat(input logic [3:0] v, input logic inc);
    return (inc && v != 4'hF) ? v + 4'd1 : v;
  endfunction

  task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed %0h expected %0h", tag, fld, obs, exp);
    end
  endtask

  // Push this cycle's expectation, sample mid-cycle, then advance past the edge.
  task automatic cyc(input string tag, input logic [31:0] ni, input logic pcw, input logic ifw,
                     input logic fl, input logic bub, input logic inc_s, input logic inc_f);
    exp_t e;
    e.tag = tag; e.ni = ni; e.pcw = pcw; e.ifw = ifw; e.fl = fl; e.bub = bub;
    e.sc = sc; e.fc = fc;
    sb.push_back(e);
    sc = sat(sc, inc_s);
    fc = sat(fc, inc_f);
    @(negedge clk);
    e = sb.pop_front();
    chk(e.tag, "next", Next_Instruction, e.ni);
    chk(e.tag, "pcw", {31'd0, PCWrite}, {31'd0, e.pcw});
    chk(e.tag, "ifw", {31'd0, IF_ID_Write}, {31'd0, e.ifw});
    chk(e.tag, "flush", {31'd0, IF_Flush}, {31'd0, e.fl});
    chk(e.tag, "bubble", {31'd0, ID_EX_Bubble}, {31'd0, e.bub});
    chk(e.tag, "stall_cnt", {28'd0, Stall_Cnt}, {28'd0, e.sc});
    chk(e.tag, "flush_cnt", {28'd0, Flush_Cnt}, {28'd0, e.fc});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IMem_Ready = 1'b1; IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0; IF_ID_UsesRt = 1'b0;
    ID_EX_MemRead = 1'b0; ID_EX_Rt = 5'd0;
    Branch_Taken = 1'b0; Branch_Target = 32'h0; Jump = 1'b0; Jump_Target = 32'h0;
  endtask

  initial begin
    rst = 1'b1; PC = 32'h40; idle();
    cyc("rst", 32'h0, 1, 1, 1, 0, 0, 0);
    rst = 1'b0;
    cyc("boot", 32'h0, 1, 1, 1, 0, 0, 0);
    cyc("run_seq", 32'h44, 1, 1, 0, 0, 0, 0);

    // load-use on Rs
    PC = 32'h44; ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd5; IF_ID_Rs = 5'd5;
    cyc("lu_rs", 32'h44, 0, 0, 0, 1, 1, 0);
    idle();
    cyc("lu_release", 32'h48, 1, 1, 0, 0, 0, 0);
    // load to $0 never stalls
    PC = 32'h48; ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd0; IF_ID_Rs = 5'd0;
    cyc("lu_r0", 32'h4C, 1, 1, 0, 0, 0, 0);
    // Rt match only counts when Rt is a source
    ID_EX_Rt = 5'd7; IF_ID_Rs = 5'd3; IF_ID_Rt = 5'd7; IF_ID_UsesRt = 1'b0;
    cyc("lu_rt_unused", 32'h4C, 1, 1, 0, 0, 0, 0);
    IF_ID_UsesRt = 1'b1;
    cyc("lu_rt_used", 32'h48, 0, 0, 0, 1, 1, 0);
    idle();
    cyc("lu_rt_release", 32'h4C, 1, 1, 0, 0, 0, 0);

    // branch, then jump+branch together
    PC = 32'h20; Branch_Taken = 1'b1; Branch_Target = 32'h100;
    cyc("branch", 32'h100, 1, 1, 1, 0, 0, 1);
    Jump = 1'b1; Jump_Target = 32'h200;
    cyc("jump_wins", 32'h200, 1, 1, 1, 0, 0, 1);
    idle(); PC = 32'h200;
    cyc("after_jump", 32'h204, 1, 1, 0, 0, 0, 0);

    // memory stall with redirects buffered
    PC = 32'h300; IMem_Ready = 1'b0; Branch_Taken = 1'b1; Branch_Target = 32'h80;
    cyc("wait_br", 32'h80, 0, 1, 1, 0, 0, 1);
    Branch_Taken = 1'b0; Jump = 1'b1; Jump_Target = 32'h90;
    cyc("wait_jmp", 32'h300, 0, 1, 1, 0, 0, 1);
    Jump = 1'b0;
    cyc("wait_hold", 32'h300, 0, 1, 1, 0, 0, 0);
    IMem_Ready = 1'b1;
    cyc("wait_ready", 32'h90, 1, 1, 1, 0, 0, 0);
    IMem_Ready = 1'b0;
    cyc("bubble_wait", 32'h300, 0, 1, 1, 0, 0, 0);
    IMem_Ready = 1'b1;
    cyc("pend_cleared", 32'h304, 1, 1, 0, 0, 0, 0);

    // LU + branch: stall only, then redirect in LU_STALL with hazard masked
    PC = 32'h500; ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd5; IF_ID_Rs = 5'd5;
    Branch_Taken = 1'b1; Branch_Target = 32'h600;
    cyc("lu_branch", 32'h500, 0, 0, 0, 1, 1, 0);
    cyc("lu_stall_br", 32'h600, 1, 1, 1, 0, 0, 1);
    idle(); PC = 32'h600;
    cyc("post_stall", 32'h604, 1, 1, 0, 0, 0, 0);

    PC = 32'hFFFF_FFFC;
    cyc("pc_wrap", 32'h0, 1, 1, 0, 0, 0, 0);

    // drive Stall_Cnt into saturation
    PC = 32'h1000;
    for (int i = 0; i < 14; i++) begin
      ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd9; IF_ID_Rs = 5'd9;
      cyc("sat_stall", 32'h1000, 0, 0, 0, 1, 1, 0);
      idle();
      cyc("sat_release", 32'h1004, 1, 1, 0, 0, 0, 0);
    end

    // reset while a redirect is pending
    PC = 32'h800; IMem_Ready = 1'b0; Branch_Taken = 1'b1; Branch_Target = 32'h700;
    cyc("pend_setup", 32'h700, 0, 1, 1, 0, 0, 1);
    Branch_Taken = 1'b0; rst = 1'b1;
    cyc("rst_in_wait", 32'h0, 1, 1, 1, 0, 0, 0);
    rst = 1'b0; sc = 4'd0; fc = 4'd0;
    cyc("boot2", 32'h0, 1, 1, 1, 0, 0, 0);
    cyc("run_not_ready", 32'h800, 0, 1, 1, 0, 0, 0);
    IMem_Ready = 1'b1;
    cyc("pend_discarded", 32'h804, 1, 1, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
